// File: rtl/maze_memory.sv
// maze_memory: maze bitmap + per-cell visited store serving a maze solver.
// Flow: CLEAR sweep (all walls, none visited) -> raster LOAD over
// valid/ready -> SERVE solver reads (1-cycle latency) and visit marks.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   row, col               solver cell address, cell index = {row, col}
//   maze_oe / maze_in      read request / registered wall bit (1 = wall)
//   maze_we                mark cell visited
//   load_valid/load_data   raster bit stream in, load_ready accepts it
//   load_done              maze loaded, solver accesses honoured
//   reload                 pulse: discard maze, restart clear/load
//   visited_cnt            distinct visited cells (saturating)
//   write_err              sticky: a wall cell was marked visited
// Optional macro MAZE_TRACE_EN adds trace_valid/trace_row/trace_col,
// a registered one-cycle echo of each accepted solver write.
module maze_memory #(
    parameter int maze_width = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [maze_width-1:0] row,
    input  logic [maze_width-1:0] col,
    input  logic                  maze_oe,
    input  logic                  maze_we,
    output logic                  maze_in,
    input  logic                  load_valid,
    input  logic                  load_data,
    output logic                  load_ready,
    output logic                  load_done,
    input  logic                  reload,
    output logic [2*maze_width:0] visited_cnt,
`ifdef MAZE_TRACE_EN
    output logic                  trace_valid,
    output logic [maze_width-1:0] trace_row,
    output logic [maze_width-1:0] trace_col,
`endif
    output logic                  write_err
);

    localparam int AW    = 2 * maze_width;
    localparam int CELLS = 1 << AW;
    localparam int CW    = AW + 1;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_LOAD,
        ST_SERVE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            maze_in_q, maze_in_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;

    logic            wall_mem [CELLS];
    logic            vis_mem  [CELLS];

    logic [AW-1:0]   rc_addr;
    logic [AW-1:0]   mem_addr;
    logic            wall_we;
    logic            wall_wd;
    logic            vis_we;
    logic            vis_wd;

`ifdef MAZE_TRACE_EN
    logic                  trace_valid_q, trace_valid_d;
    logic [maze_width-1:0] trace_row_q, trace_row_d;
    logic [maze_width-1:0] trace_col_q, trace_col_d;
`endif

    assign rc_addr = {row, col};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        maze_in_d = maze_in_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        mem_addr  = addr_q;
        wall_we   = 1'b0;
        wall_wd   = 1'b1;
        vis_we    = 1'b0;
        vis_wd    = 1'b0;
`ifdef MAZE_TRACE_EN
        trace_valid_d = 1'b0;
        trace_row_d   = trace_row_q;
        trace_col_d   = trace_col_q;
`endif
        if (reload) begin
            // Reload wins over any same-cycle handshake or solver access.
            state_d   = ST_CLEAR;
            addr_d    = '0;
            maze_in_d = 1'b1;
            cnt_d     = '0;
            err_d     = 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    wall_we   = 1'b1;
                    wall_wd   = 1'b1;
                    vis_we    = 1'b1;
                    vis_wd    = 1'b0;
                    maze_in_d = 1'b1;
                    addr_d    = addr_q + 1'b1;
                    if (addr_q == '1) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    maze_in_d = 1'b1;
                    if (load_valid) begin
                        wall_we = 1'b1;
                        wall_wd = load_data;
                        addr_d  = addr_q + 1'b1;
                        if (addr_q == '1) begin
                            state_d = ST_SERVE;
                        end
                    end
                end
                ST_SERVE: begin
                    mem_addr = rc_addr;
                    if (maze_oe) begin
                        // Read sees the wall bit, never the visit mark.
                        maze_in_d = wall_mem[rc_addr];
                    end
                    if (maze_we) begin
                        vis_we = 1'b1;
                        vis_wd = 1'b1;
                        if (!vis_mem[rc_addr] && (cnt_q != '1)) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (wall_mem[rc_addr]) begin
                            err_d = 1'b1;
                        end
`ifdef MAZE_TRACE_EN
                        trace_valid_d = 1'b1;
                        trace_row_d   = row;
                        trace_col_d   = col;
`endif
                    end
                end
                default: begin
                    state_d   = ST_CLEAR;
                    addr_d    = '0;
                    maze_in_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            addr_q    <= '0;
            maze_in_q <= 1'b1;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            maze_in_q <= maze_in_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    // Storage arrays carry no reset; the CLEAR sweep initialises them.
    always_ff @(posedge clk) begin
        if (wall_we) begin
            wall_mem[mem_addr] <= wall_wd;
        end
        if (vis_we) begin
            vis_mem[mem_addr] <= vis_wd;
        end
    end

`ifdef MAZE_TRACE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_valid_q <= 1'b0;
            trace_row_q   <= '0;
            trace_col_q   <= '0;
        end else begin
            trace_valid_q <= trace_valid_d;
            trace_row_q   <= trace_row_d;
            trace_col_q   <= trace_col_d;
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_row   = trace_row_q;
    assign trace_col   = trace_col_q;
`endif

    assign maze_in     = maze_in_q;
    assign load_ready  = (state_q == ST_LOAD);
    assign load_done   = (state_q == ST_SERVE);
    assign visited_cnt = cnt_q;
    assign write_err   = err_q;

endmodule

// File: tb/tb_maze_memory.sv
// tb_maze_memory: randomized self-checking bench for maze_memory.
// Reference model: plain arrays of wall/visited bits plus counters.
module tb_maze_memory;

    localparam int MW    = 6;
    localparam int CELLS = 4096;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [MW-1:0] row;
    logic [MW-1:0] col;
    logic          maze_oe;
    logic          maze_we;
    logic          maze_in;
    logic          load_valid;
    logic          load_data;
    logic          load_ready;
    logic          load_done;
    logic          reload;
    logic [2*MW:0] visited_cnt;
    logic          write_err;
`ifdef MAZE_TRACE_EN
    logic          trace_valid;
    logic [MW-1:0] trace_row;
    logic [MW-1:0] trace_col;
`endif

    always #5 clk = ~clk;

    maze_memory #(.maze_width(MW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row         (row),
        .col         (col),
        .maze_oe     (maze_oe),
        .maze_we     (maze_we),
        .maze_in     (maze_in),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .reload      (reload),
        .visited_cnt (visited_cnt),
`ifdef MAZE_TRACE_EN
        .trace_valid (trace_valid),
        .trace_row   (trace_row),
        .trace_col   (trace_col),
`endif
        .write_err   (write_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    bit img    [CELLS];
    bit wall_m [CELLS];
    bit vis_m  [CELLS];
    int cnt_m;
    bit err_m;
    bit in_m;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        maze_oe    = 1'b0;
        maze_we    = 1'b0;
        load_valid = 1'b0;
        load_data  = 1'b0;
        reload     = 1'b0;
    endtask

    task automatic model_clear();
        cnt_m = 0;
        err_m = 1'b0;
        in_m  = 1'b1;
        for (int i = 0; i < CELLS; i++) begin
            vis_m[i]  = 1'b0;
            wall_m[i] = 1'b1;
        end
    endtask

    // One solver access; model follows the read/visit rules directly.
    task automatic serve_op(input bit oe, input bit we,
                            input int r, input int c);
        int a;
        a       = r * 64 + c;
        row     = 6'(r);
        col     = 6'(c);
        maze_oe = oe;
        maze_we = we;
        step();
        maze_oe = 1'b0;
        maze_we = 1'b0;
        if (oe) in_m = wall_m[a];
        if (we) begin
            if (!vis_m[a]) cnt_m++;
            vis_m[a] = 1'b1;
            if (wall_m[a]) err_m = 1'b1;
        end
    endtask

    // Count cycles from now until load_ready rises; expect a full sweep.
    task automatic wait_ready(input string name);
        int cyc;
        bit bad;
        cyc = 0;
        bad = 1'b0;
        while (load_ready !== 1'b1 && cyc < 6000) begin
            if (maze_in !== 1'b1 || load_done !== 1'b0) bad = 1'b1;
            step();
            cyc++;
        end
        n_checks++;
        if (cyc !== 4096)
            $display("FAIL %s clear_cycles got %0d exp 4096", name, cyc);
        else n_pass++;
        n_checks++;
        if (bad)
            $display("FAIL %s clear_outputs got bad exp maze_in=1 done=0",
                     name);
        else n_pass++;
    endtask

    // Stream nbits of img with random valid gaps; noisy solver inputs.
    task automatic load_maze(input int nbits, input string name);
        int  i;
        int  guard;
        bit  acc;
        bit  early;
        i     = 0;
        guard = 0;
        early = 1'b0;
        while (i < nbits && guard < 20000) begin
            load_valid = ($urandom_range(0, 3) != 0);
            load_data  = img[i];
            maze_we    = ($urandom_range(0, 1) == 1);
            maze_oe    = ($urandom_range(0, 1) == 1);
            row        = 6'($urandom_range(0, 63));
            col        = 6'($urandom_range(0, 63));
            acc        = load_valid && (load_ready === 1'b1);
            if (load_done !== 1'b0) early = 1'b1;
            step();
            if (acc) i++;
            guard++;
        end
        idle();
        n_checks++;
        if (i !== nbits)
            $display("FAIL %s bits_accepted got %0d exp %0d", name, i, nbits);
        else n_pass++;
        n_checks++;
        if (early)
            $display("FAIL %s load_done_early got 1 exp 0", name);
        else n_pass++;
        n_checks++;
        if (visited_cnt !== 13'd0 || write_err !== 1'b0 || maze_in !== 1'b1)
            $display("FAIL %s ignored_access got cnt=%0d err=%0b in=%0b exp 0 0 1",
                     name, visited_cnt, write_err, maze_in);
        else n_pass++;
        n_checks++;
        if (nbits == CELLS) begin
            if (load_ready !== 1'b0 || load_done !== 1'b1)
                $display("FAIL %s after_load got rdy=%0b done=%0b exp 0 1",
                         name, load_ready, load_done);
            else n_pass++;
        end else begin
            if (load_ready !== 1'b1 || load_done !== 1'b0)
                $display("FAIL %s mid_load got rdy=%0b done=%0b exp 1 0",
                         name, load_ready, load_done);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        row   = '0;
        col   = '0;
        idle();
        step();
        step();
        n_checks++;
        if (maze_in !== 1'b1 || load_ready !== 1'b0 || load_done !== 1'b0)
            $display("FAIL reset_ctrl got in=%0b rdy=%0b done=%0b exp 1 0 0",
                     maze_in, load_ready, load_done);
        else n_pass++;
        n_checks++;
        if (visited_cnt !== 13'd0 || write_err !== 1'b0)
            $display("FAIL reset_cnt got cnt=%0d err=%0b exp 0 0",
                     visited_cnt, write_err);
        else n_pass++;
`ifdef MAZE_TRACE_EN
        n_checks++;
        if (trace_valid !== 1'b0 || trace_row !== 6'd0 || trace_col !== 6'd0)
            $display("FAIL reset_trace got v=%0b r=%0d c=%0d exp 0 0 0",
                     trace_valid, trace_row, trace_col);
        else n_pass++;
`endif
        rst_n = 1'b1;
        model_clear();
        wait_ready("reset");
    endtask

    task automatic test_load_row5();
        for (int i = 0; i < CELLS; i++) img[i] = (i / 64 != 5);
        load_maze(CELLS, "row5");
        for (int i = 0; i < CELLS; i++) wall_m[i] = img[i];
        serve_op(1'b1, 1'b0, 5, 10);
        n_checks++;
        if (maze_in !== 1'b0)
            $display("FAIL read_free got %0b exp 0", maze_in);
        else n_pass++;
        serve_op(1'b1, 1'b0, 4, 10);
        n_checks++;
        if (maze_in !== 1'b1)
            $display("FAIL read_wall got %0b exp 1", maze_in);
        else n_pass++;
        serve_op(1'b1, 1'b0, 5, 63);
        step();
        n_checks++;
        if (maze_in !== 1'b0)
            $display("FAIL read_hold got %0b exp 0", maze_in);
        else n_pass++;
    endtask

    task automatic test_visit();
        serve_op(1'b0, 1'b1, 5, 10);
        serve_op(1'b0, 1'b1, 5, 10);
        serve_op(1'b0, 1'b1, 5, 11);
        n_checks++;
        if (visited_cnt !== 13'd2 || write_err !== 1'b0)
            $display("FAIL visit_free got cnt=%0d err=%0b exp 2 0",
                     visited_cnt, write_err);
        else n_pass++;
        serve_op(1'b0, 1'b1, 4, 10);
        n_checks++;
        if (visited_cnt !== 13'd3 || write_err !== 1'b1)
            $display("FAIL visit_wall got cnt=%0d err=%0b exp 3 1",
                     visited_cnt, write_err);
        else n_pass++;
    endtask

    task automatic test_oe_we();
        serve_op(1'b1, 1'b1, 5, 12);
        n_checks++;
        if (maze_in !== 1'b0 || visited_cnt !== 13'd4)
            $display("FAIL oe_we got in=%0b cnt=%0d exp 0 4",
                     maze_in, visited_cnt);
        else n_pass++;
    endtask

`ifdef MAZE_TRACE_EN
    task automatic test_trace();
        serve_op(1'b0, 1'b1, 5, 20);
        n_checks++;
        if (trace_valid !== 1'b1 || trace_row !== 6'd5 || trace_col !== 6'd20)
            $display("FAIL trace_pulse got v=%0b r=%0d c=%0d exp 1 5 20",
                     trace_valid, trace_row, trace_col);
        else n_pass++;
        step();
        n_checks++;
        if (trace_valid !== 1'b0)
            $display("FAIL trace_single got %0b exp 0", trace_valid);
        else n_pass++;
    endtask
`endif

    task automatic test_random_serve(input string name);
        bit oe;
        bit we;
        int r;
        for (int k = 0; k < 400; k++) begin
            oe = ($urandom_range(0, 1) == 1);
            we = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 3) == 0) ? 5 : $urandom_range(0, 63);
            serve_op(oe, we, r, $urandom_range(0, 63));
            n_checks++;
            if (maze_in !== in_m || visited_cnt !== 13'(cnt_m) ||
                write_err !== err_m)
                $display("FAIL %s op%0d got in=%0b cnt=%0d err=%0b exp %0b %0d %0b",
                         name, k, maze_in, visited_cnt, write_err,
                         in_m, cnt_m, err_m);
            else n_pass++;
        end
    endtask

    task automatic test_reload_serve();
        row     = 6'd5;
        col     = 6'd40;
        maze_we = 1'b1;
        maze_oe = 1'b1;
        reload  = 1'b1;
        step();
        idle();
        model_clear();
        n_checks++;
        if (load_done !== 1'b0 || load_ready !== 1'b0 || maze_in !== 1'b1)
            $display("FAIL reload_ctrl got done=%0b rdy=%0b in=%0b exp 0 0 1",
                     load_done, load_ready, maze_in);
        else n_pass++;
        n_checks++;
        if (visited_cnt !== 13'd0 || write_err !== 1'b0)
            $display("FAIL reload_cnt got cnt=%0d err=%0b exp 0 0",
                     visited_cnt, write_err);
        else n_pass++;
        wait_ready("reload");
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < CELLS; i++) img[i] = ($urandom_range(0, 1) == 1);
        load_maze(2000, "partial");
        rst_n = 1'b0;
        step();
        n_checks++;
        if (load_ready !== 1'b0 || load_done !== 1'b0)
            $display("FAIL midload_rst got rdy=%0b done=%0b exp 0 0",
                     load_ready, load_done);
        else n_pass++;
        rst_n = 1'b1;
        model_clear();
        wait_ready("midload");
        for (int i = 0; i < CELLS; i++) img[i] = ($urandom_range(0, 2) == 0);
        load_maze(CELLS, "rand");
        for (int i = 0; i < CELLS; i++) wall_m[i] = img[i];
        test_random_serve("rand_maze");
    endtask

    initial begin
        test_reset();
        test_load_row5();
        test_visit();
        test_oe_we();
`ifdef MAZE_TRACE_EN
        test_trace();
`endif
        test_random_serve("row5_maze");
        test_reload_serve();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
